// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: block geometry, padding constants, padder FSM
// states, round constants and initial hash values used by the compression core.
package sha256_pkg;

  localparam int BLOCK_W     = 512;
  localparam int LEN_FIELD_W = 64;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int LEN_OFFSET  = 56;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    EMIT = 1'b1
  } pad_state_e;

  localparam logic [31:0] K256 [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] H256_INIT [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_padder.sv
// Byte-stream to 512-bit block padder for the SHA-256 core (0x80, zero fill, length).
// Optional macro SHA256_PAD_OVF_EN adds the sticky len_ovf byte-counter wrap flag.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_keep,
  input  logic               in_last,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               blk_last
`ifdef SHA256_PAD_OVF_EN
  ,
  output logic               len_ovf
`endif
);

  localparam int LEN_MSB = (BLOCK_W / 8 - LEN_OFFSET) * 8 - 1;

  pad_state_e         state_r, state_s;
  logic [5:0]         ptr_r, ptr_s;
  logic [LEN_W-1:0]   cnt_r, cnt_s;
  logic               extra_r, extra_s;
  logic               placed_r, placed_s;
  logic               last_r, last_s;
  logic [BLOCK_W-1:0] buf_r, buf_s;
  logic [6:0]         pos_s;

  // Byte 0 lives in the top byte lane, so lane offset is (63 - idx) * 8 == {~idx, 3'b000}.
  function automatic logic [BLOCK_W-1:0] put_byte(input logic [BLOCK_W-1:0] b,
                                                  input logic [5:0] idx,
                                                  input logic [7:0] v);
    logic [BLOCK_W-1:0] r;
    r = b;
    r[{~idx, 3'b000} +: 8] = v;
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] put_len(input logic [BLOCK_W-1:0] b,
                                                 input logic [LEN_W-1:0] cnt);
    logic [BLOCK_W-1:0] r;
    r = b;
    r[LEN_MSB -: LEN_FIELD_W] = LEN_FIELD_W'({cnt, 3'b000});
    return r;
  endfunction

  // Next-state and buffer update for FILL/EMIT.
  always_comb begin
    state_s  = state_r;
    ptr_s    = ptr_r;
    cnt_s    = cnt_r;
    extra_s  = extra_r;
    placed_s = placed_r;
    last_s   = last_r;
    buf_s    = buf_r;
    pos_s    = 7'd0;
    case (state_r)
      FILL: begin
        if (in_valid) begin
          if (in_keep) begin
            buf_s = put_byte(buf_s, ptr_r, in_data);
            ptr_s = ptr_r + 6'd1;
            cnt_s = cnt_r + LEN_W'(1);
            pos_s = {1'b0, ptr_r} + 7'd1;
          end else begin
            pos_s = {1'b0, ptr_r};
          end
          if (in_last) begin
            // pos_s is where the 0x80 goes; 64 means it spills into the extra block.
            if (pos_s <= 7'd63) begin
              buf_s = put_byte(buf_s, pos_s[5:0], PAD_BYTE);
            end else begin
              buf_s = buf_s;
            end
            state_s = EMIT;
            if (pos_s <= 7'd55) begin
              buf_s  = put_len(buf_s, cnt_s);
              last_s = 1'b1;
            end else begin
              last_s   = 1'b0;
              extra_s  = 1'b1;
              placed_s = (pos_s <= 7'd63);
            end
          end else if (in_keep && (ptr_r == 6'd63)) begin
            state_s = EMIT;
            last_s  = 1'b0;
          end else begin
            state_s = FILL;
          end
        end else begin
          state_s = FILL;
        end
      end
      EMIT: begin
        if (blk_ready) begin
          buf_s = '0;
          ptr_s = 6'd0;
          if (extra_r) begin
            if (!placed_r) begin
              buf_s = put_byte(buf_s, 6'd0, PAD_BYTE);
            end else begin
              buf_s = buf_s;
            end
            buf_s    = put_len(buf_s, cnt_r);
            last_s   = 1'b1;
            extra_s  = 1'b0;
            placed_s = 1'b0;
            state_s  = EMIT;
          end else if (last_r) begin
            cnt_s   = '0;
            last_s  = 1'b0;
            state_s = FILL;
          end else begin
            state_s = FILL;
          end
        end else begin
          state_s = EMIT;
        end
      end
      default: begin
        state_s = FILL;
      end
    endcase
  end

  // State and block buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= FILL;
      ptr_r    <= 6'd0;
      cnt_r    <= '0;
      extra_r  <= 1'b0;
      placed_r <= 1'b0;
      last_r   <= 1'b0;
      buf_r    <= '0;
    end else begin
      state_r  <= state_s;
      ptr_r    <= ptr_s;
      cnt_r    <= cnt_s;
      extra_r  <= extra_s;
      placed_r <= placed_s;
      last_r   <= last_s;
      buf_r    <= buf_s;
    end
  end

  assign in_ready  = (state_r == FILL);
  assign blk_valid = (state_r == EMIT);
  assign blk_data  = buf_r;
  assign blk_last  = last_r;

`ifdef SHA256_PAD_OVF_EN
  logic ovf_r, ovf_s;

  // Sticky wrap flag, released by the final-block handshake.
  always_comb begin
    ovf_s = ovf_r;
    if ((state_r == FILL) && in_valid && in_keep && (&cnt_r)) begin
      ovf_s = 1'b1;
    end else if ((state_r == EMIT) && blk_ready && last_r && !extra_r) begin
      ovf_s = 1'b0;
    end else begin
      ovf_s = ovf_r;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_s;
    end
  end

  assign len_ovf = ovf_r;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: table vectors, hand-written corner
// sequences and randomized messages against a queue-based padding model.
module tb_sha256_padder;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    int len;
    bit term;
    int nblk;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_keep, in_last;
  logic [7:0]   in_data;
  logic         blk_valid, blk_ready, blk_last;
  logic [511:0] blk_data;
`ifdef SHA256_PAD_OVF_EN
  logic         len_ovf;
`endif

  int total = 0;
  int bad   = 0;
  int ready_mode = 1;  // 0 random, 1 always high, 2 always low
  bit gap_en = 1'b0;

  logic [511:0] cap_data[$];
  bit           cap_last[$];
  logic [511:0] exp_q[$];

  always #5 clk = ~clk;

  sha256_padder #(.LEN_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_last(blk_last)
`ifdef SHA256_PAD_OVF_EN
    , .len_ovf(len_ovf)
`endif
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, note handshakes that the next posedge will perform.
  task automatic cycle(input logic v, input logic k, input logic l, input logic [7:0] d,
                       output bit acc);
    @(negedge clk);
    in_valid = v;
    in_keep  = k;
    in_last  = l;
    in_data  = d;
    case (ready_mode)
      0:       blk_ready = ($urandom_range(0, 2) != 0);
      1:       blk_ready = 1'b1;
      default: blk_ready = 1'b0;
    endcase
    acc = v && in_ready && !rst;
    if (blk_valid && blk_ready && !rst) begin
      cap_data.push_back(blk_data);
      cap_last.push_back(blk_last);
    end
  endtask

  task automatic send(input byte_q_t msg, input bit term);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < msg.size() && guard < 5000) begin
      bit v;
      v = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle(v, 1'b1, (i == msg.size() - 1) && !term, msg[i], acc);
      if (acc) i++;
      guard++;
    end
    if (term) begin
      acc = 1'b0;
      while (!acc && guard < 5000) begin
        cycle(1'b1, 1'b0, 1'b1, 8'h00, acc);
        guard++;
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00, acc);
    if (guard >= 5000) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got %0d beats want %0d", i, msg.size());
    end
  endtask

  task automatic drain(input int nexp);
    int guard = 0;
    bit acc;
    while (cap_data.size() < nexp && guard < 500) begin
      cycle(1'b0, 1'b0, 1'b0, 8'h00, acc);
      guard++;
    end
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 8'h00, acc);
  endtask

  // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
  function automatic void build_exp(input byte_q_t msg);
    byte_q_t q;
    logic [63:0] lenbits;
    logic [511:0] blk;
    exp_q.delete();
    q = msg;
    q.push_back(8'h80);
    while (q.size() % 64 != 56) q.push_back(8'h00);
    lenbits = 64'(msg.size()) * 64'd8;
    for (int j = 7; j >= 0; j--) q.push_back(lenbits[8*j +: 8]);
    for (int b = 0; b < q.size() / 64; b++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) blk[511 - 8*i -: 8] = q[64*b + i];
      exp_q.push_back(blk);
    end
  endfunction

  task automatic run_msg(input string name, input byte_q_t msg, input bit term, input int nblk);
    cap_data.delete();
    cap_last.delete();
    build_exp(msg);
    send(msg, term);
    drain(nblk);
    check($sformatf("%s nblk", name), 512'(cap_data.size()), 512'(nblk));
    for (int b = 0; b < exp_q.size(); b++) begin
      if (b < cap_data.size()) begin
        check($sformatf("%s blk%0d data", name, b), cap_data[b], exp_q[b]);
        check($sformatf("%s blk%0d last", name, b), 512'(cap_last[b]),
              512'(b == exp_q.size() - 1));
      end
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, " in_ready"}, 512'(in_ready), 512'(1));
    check({name, " blk_valid"}, 512'(blk_valid), 512'(0));
    check({name, " blk_last"}, 512'(blk_last), 512'(0));
    check({name, " blk_data"}, blk_data, 512'(0));
  endtask

  initial begin
    vec_t vecs[13];
    byte_q_t msg;
    byte_q_t abc;
    logic [511:0] abc_blk, k;
    bit acc;
    int guard;

    vecs[0]  = '{3, 1'b0, 1};
    vecs[1]  = '{0, 1'b1, 1};
    vecs[2]  = '{55, 1'b0, 1};
    vecs[3]  = '{56, 1'b0, 2};
    vecs[4]  = '{64, 1'b0, 2};
    vecs[5]  = '{63, 1'b0, 2};
    vecs[6]  = '{54, 1'b1, 1};
    vecs[7]  = '{55, 1'b1, 1};
    vecs[8]  = '{56, 1'b1, 2};
    vecs[9]  = '{64, 1'b1, 2};
    vecs[10] = '{119, 1'b0, 2};
    vecs[11] = '{120, 1'b0, 3};
    vecs[12] = '{128, 1'b0, 3};

    abc = '{8'h61, 8'h62, 8'h63};
    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[63:0] = 64'h18;

    rst = 1'b1;
    in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0; in_data = 8'h00; blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
`ifdef SHA256_PAD_OVF_EN
    check("reset len_ovf", 512'(len_ovf), 512'(0));
`endif
    rst = 1'b0;

    // "abc" against a literal block
    ready_mode = 1;
    run_msg("abc", abc, 1'b0, 1);
    if (cap_data.size() > 0) check("abc literal", cap_data[0], abc_blk);

    // Empty message via terminator-only beat
    msg.delete();
    run_msg("empty", msg, 1'b1, 1);
    k = '0; k[511:504] = 8'h80;
    if (cap_data.size() > 0) check("empty literal", cap_data[0], k);

    // Table of lengths around the 55/56/63/64 boundaries
    for (int v = 0; v < 13; v++) begin
      msg.delete();
      for (int i = 0; i < vecs[v].len; i++) msg.push_back(8'(i));
      run_msg($sformatf("vec%0d_len%0d", v, vecs[v].len), msg, vecs[v].term, vecs[v].nblk);
      if (v == 2 && cap_data.size() > 0) check("len55 length", 512'(cap_data[0][63:0]), 512'(64'h1B8));
      if (v == 3 && cap_data.size() > 1) check("len56 length", 512'(cap_data[1][63:0]), 512'(64'h1C0));
      if (v == 4 && cap_data.size() > 1) begin
        k = '0; k[511:504] = 8'h80; k[63:0] = 64'h200;
        check("len64 blk1 literal", cap_data[1], k);
      end
    end

    // Stall: block held stable with in_ready low while blk_ready stays low
    cap_data.delete(); cap_last.delete();
    ready_mode = 2;
    send(abc, 1'b0);
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, 1'b1, 1'b0, 8'h55, acc);
      check($sformatf("stall%0d data", c), blk_data, abc_blk);
      check($sformatf("stall%0d in_ready", c), 512'(in_ready), 512'(0));
      check($sformatf("stall%0d accepted", c), 512'(acc), 512'(0));
    end
    ready_mode = 1;
    drain(1);
    check("stall nblk", 512'(cap_data.size()), 512'(1));
    if (cap_data.size() > 0) check("stall data", cap_data[0], abc_blk);

    // Reset mid-message discards the partial block
    cap_data.delete(); cap_last.delete();
    cycle(1'b1, 1'b1, 1'b0, 8'h11, acc);
    cycle(1'b1, 1'b1, 1'b0, 8'h22, acc);
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 8'h00, acc);
    rst = 1'b0;
    check_reset_state("rst_mid_msg");
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 8'h00, acc);
    check("rst_mid_msg no block", 512'(cap_data.size()), 512'(0));
    run_msg("abc_after_rst", abc, 1'b0, 1);

    // Reset while a block is waiting in EMIT
    cap_data.delete(); cap_last.delete();
    ready_mode = 2;
    send(abc, 1'b0);
    guard = 0;
    while (!blk_valid && guard < 20) begin
      cycle(1'b0, 1'b0, 1'b0, 8'h00, acc);
      guard++;
    end
    check("emit before rst", 512'(blk_valid), 512'(1));
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 8'h00, acc);
    rst = 1'b0;
    check_reset_state("rst_mid_emit");
    ready_mode = 1;
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 8'h00, acc);
    check("rst_mid_emit no block", 512'(cap_data.size()), 512'(0));

    // Randomized messages with input gaps and downstream backpressure
    ready_mode = 0;
    gap_en = 1'b1;
    for (int t = 0; t < 15; t++) begin
      int len;
      bit term;
      len = $urandom_range(0, 150);
      term = (len == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      run_msg($sformatf("rand%0d_len%0d", t, len), msg, term, (len + 9 + 63) / 64);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
